counting_seq_gen: RTL and testbench
===================================

# counting_seq_gen

Stimulus generator for the 2-bit symbol protocol that the sequence detectors in this design consume. On a start request it emits a burst of `01` symbols of programmable length, followed by `10` and then `11`, and otherwise idles on `00`. It drives detector inputs in both the test harness and the system. An optional built-in monitor checks that the emitted stream completes the detect pattern.

## Interface
- CNT_W, 4, width of the `ones` burst-length operand and of the internal down-counter
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new sequence; sampled only in IDLE
- ones  input  CNT_W  number of `01` symbols in the burst; captured with start; 0 treated as 1
- abort  input  1  cancel the sequence in progress; highest priority after reset
- num  output  2  registered symbol output
- busy  output  1  high while a non-`00` sequence symbol is on num
- done  output  1  one-cycle pulse after the final `11` symbol
- seen  output  1  monitor result, sticky (see Configuration)

## Operation
- States: IDLE, ONES, TWO, THREE.
- Outputs are registered and decoded from the state:
  - IDLE: num=00, busy=0
  - ONES: num=01, busy=1
  - TWO: num=10, busy=1
  - THREE: num=11, busy=1
- IDLE:
  - start=1 loads cnt = (ones==0 ? 1 : ones) and moves to ONES.
  - start=0 stays in IDLE.
- ONES:
  - cnt>1: decrement cnt, stay in ONES.
  - cnt==1: go to TWO.
- TWO: go to THREE unconditionally.
- THREE: go to IDLE and set done=1 for the next cycle only.
- start outside IDLE is ignored. There is no queueing.
- abort=1 in any busy state: next state IDLE, num=00, no done pulse, cnt is don't-care. abort in IDLE has no effect. abort and start together in IDLE: abort wins, so the start is dropped.
- reset=1: state=IDLE, cnt=0, num=00, busy=0, done=0, seen=0. Mid-sequence reset discards the sequence with no done pulse.
- Counter arithmetic is unsigned CNT_W bits. The maximum burst is 2^CNT_W−1 `01` symbols. Decrement never wraps, because ONES exits at cnt==1.

## Timing
- start sampled at edge t puts the first `01` on num in the cycle after edge t.
- A sequence occupies exactly N+2 consecutive cycles with busy=1, where N is the effective ones value.
- done rises the cycle after the `11` cycle, with num=00 and busy=0. The next start is accepted in that same cycle, so back-to-back sequences have exactly one `00` cycle between them.
- abort sampled at edge t gives num=00 in cycle t+1.

## Configuration
- COUNTING_GEN_SELFCHECK_EN defined: include the 4-state monitor M0..M3, sampling num at every clk edge.
  - M0: 01→M1, otherwise M0.
  - M1: 01→M1, 10→M2, otherwise M0.
  - M2: 01→M1, 11→M3, otherwise M0.
  - M3: sticky.
  - seen = (M==M3). It rises in the same cycle as done.
  - The monitor clears to M0 on reset or on an accepted start.
- Not defined: no monitor logic; seen is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then start with ones=3: num is 01,01,01,10,11,00; busy is high for exactly 5 cycles; done pulses once in the 00 cycle. With SELFCHECK, seen=1 from that cycle on.
- start with ones=0: num is 01,10,11, identical to ones=1.
- start with ones=15 (CNT_W=4): 15×01 then 10,11; busy high for 17 cycles; no counter wrap.
- Assert start on the done cycle with ones=2: the sequences are separated by exactly one 00 cycle, and the second burst is 01,01,10,11. With SELFCHECK, seen clears on the accepted start, then re-asserts.
- abort during TWO: num=00 on the next cycle, done never pulses, seen stays 0. A start issued during the busy period before the abort is ignored.
- reset asserted during ONES with ones=5: the next cycle shows num=00, busy=0, done=0, seen=0, and the generator accepts a fresh start.

Source files
------------

// File: rtl/counting_seq_if.sv
// Symbol-generator bus: start/ones/abort request side, num/busy/done/seen result side.
// master drives requests; slave (the generator) drives the registered symbol stream.
interface counting_seq_if #(parameter int CNT_W = 4);
   logic             start;
   logic [CNT_W-1:0] ones;
   logic             abort;
   logic [1:0]       num;
   logic             busy;
   logic             done;
   logic             seen;

   modport master (output start, ones, abort, input num, busy, done, seen);
   modport slave  (input start, ones, abort, output num, busy, done, seen);
endinterface

// File: rtl/counting_seq_gen.sv
// Emits N x 01, then 10, 11 on start; first symbol one cycle after start, no queueing, abort drops to 00.
// COUNTING_GEN_SELFCHECK_EN adds a sticky monitor on num driving seen; otherwise seen is 0.
module counting_seq_gen #(
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   counting_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ONES, TWO, THREE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             done_q, done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      if (bus.abort && state != IDLE) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               // abort alongside start in IDLE drops the request
               if (bus.start && !bus.abort) begin
                  state_nxt = ONES;
                  cnt_nxt   = (bus.ones == '0) ? CNT_W'(1) : bus.ones;
               end
            end
            ONES: begin
               if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
               else                 state_nxt = TWO;
            end
            TWO: state_nxt = THREE;
            THREE: begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.num  = 2'b00;
      bus.busy = 1'b0;
      case (state)
         ONES:  begin bus.num = 2'b01; bus.busy = 1'b1; end
         TWO:   begin bus.num = 2'b10; bus.busy = 1'b1; end
         THREE: begin bus.num = 2'b11; bus.busy = 1'b1; end
         default: begin bus.num = 2'b00; bus.busy = 1'b0; end
      endcase
   end

   assign bus.done = done_q;

`ifdef COUNTING_GEN_SELFCHECK_EN
   typedef enum logic [1:0] {M0, M1, M2, M3} mon_t;

   mon_t mon, mon_nxt;
   logic accept;

   assign accept = (state == IDLE) && bus.start && !bus.abort;

   always_comb begin
      mon_nxt = M0;
      if (mon == M3) begin
         mon_nxt = M3;
      end else begin
         case (bus.num)
            2'b01:   mon_nxt = M1;
            2'b10:   mon_nxt = (mon == M1) ? M2 : M0;
            2'b11:   mon_nxt = (mon == M2) ? M3 : M0;
            default: mon_nxt = M0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || accept) mon <= M0;
      else                 mon <= mon_nxt;
   end

   assign bus.seen = (mon == M3);
`else
   assign bus.seen = 1'b0;
`endif

endmodule

// File: tb/tb_counting_seq_gen.sv
// Table-driven bench for counting_seq_gen: per-cycle vectors feed a scoreboard queue, checked after each edge.
module tb_counting_seq_gen;

   logic clk;
   logic reset;

   counting_seq_if #(.CNT_W(4)) bus();

   counting_seq_gen #(.CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic       st;
      logic [3:0] ones;
      logic       ab;
      logic [1:0] num;
      logic       busy;
      logic       done;
      logic       seen;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input string name, input logic rst, input logic st, input logic [3:0] ones,
                      input logic ab, input logic [1:0] num, input logic busy, input logic done,
                      input logic seen);
      vec_t v;
      v.name = name; v.rst = rst; v.st = st; v.ones = ones; v.ab = ab;
      v.num = num; v.busy = busy; v.done = done; v.seen = seen;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
   task automatic apply(input vec_t v);
      vec_t e;
      logic exp_seen;
      reset     = v.rst;
      bus.start = v.st;
      bus.ones  = v.ones;
      bus.abort = v.ab;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
`ifdef COUNTING_GEN_SELFCHECK_EN
      exp_seen = e.seen;
`else
      exp_seen = 1'b0;
`endif
      chk({e.name, ".num"},  {30'd0, bus.num},  {30'd0, e.num});
      chk({e.name, ".busy"}, {31'd0, bus.busy}, {31'd0, e.busy});
      chk({e.name, ".done"}, {31'd0, bus.done}, {31'd0, e.done});
      chk({e.name, ".seen"}, {31'd0, bus.seen}, {31'd0, exp_seen});
   endtask

   task automatic tick(input logic st, input logic [3:0] ones);
      reset     = 1'b0;
      bus.start = st;
      bus.ones  = ones;
      bus.abort = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic found;
      vec_t v;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.ones  = '0;
      bus.abort = 1'b0;

      add("rst0", 1, 0, 0, 0, 2'b00, 0, 0, 0);
      add("rst1", 1, 0, 0, 0, 2'b00, 0, 0, 0);

      add("o3_start", 0, 1, 3, 0, 2'b01, 1, 0, 0);
      add("o3_one",   0, 0, 0, 0, 2'b01, 1, 0, 0);
      add("o3_one",   0, 0, 0, 0, 2'b01, 1, 0, 0);
      add("o3_two",   0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("o3_three", 0, 0, 0, 0, 2'b11, 1, 0, 0);
      add("o3_done",  0, 0, 0, 0, 2'b00, 0, 1, 1);
      add("o3_idle",  0, 0, 0, 0, 2'b00, 0, 0, 1);

      add("o0_start", 0, 1, 0, 0, 2'b01, 1, 0, 0);
      add("o0_two",   0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("o0_three", 0, 0, 0, 0, 2'b11, 1, 0, 0);
      add("o0_done",  0, 0, 0, 0, 2'b00, 0, 1, 1);

      add("o1_start", 0, 1, 1, 0, 2'b01, 1, 0, 0);
      add("o1_two",   0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("o1_three", 0, 0, 0, 0, 2'b11, 1, 0, 0);
      add("o1_done",  0, 0, 0, 0, 2'b00, 0, 1, 1);

      add("o15_start", 0, 1, 15, 0, 2'b01, 1, 0, 0);
      for (int i = 0; i < 14; i++) add("o15_one", 0, 0, 0, 0, 2'b01, 1, 0, 0);
      add("o15_two",   0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("o15_three", 0, 0, 0, 0, 2'b11, 1, 0, 0);
      add("o15_done",  0, 0, 0, 0, 2'b00, 0, 1, 1);
      add("o15_idle",  0, 0, 0, 0, 2'b00, 0, 0, 1);

      // abort with start in IDLE: start is dropped, monitor keeps its state
      add("abidle",      0, 1, 3, 1, 2'b00, 0, 0, 1);
      add("abidle_stay", 0, 0, 0, 0, 2'b00, 0, 0, 1);

      add("ab_start",  0, 1, 2, 0, 2'b01, 1, 0, 0);
      add("ab_ignst",  0, 1, 5, 0, 2'b01, 1, 0, 0);
      add("ab_two",    0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("ab_abort",  0, 0, 0, 1, 2'b00, 0, 0, 0);
      for (int i = 0; i < 3; i++) add("ab_after", 0, 0, 0, 0, 2'b00, 0, 0, 0);

      add("rs_start", 0, 1, 5, 0, 2'b01, 1, 0, 0);
      add("rs_one",   0, 0, 0, 0, 2'b01, 1, 0, 0);
      add("rs_reset", 1, 0, 0, 0, 2'b00, 0, 0, 0);
      add("rs_idle",  0, 0, 0, 0, 2'b00, 0, 0, 0);
      add("rs_new",   0, 1, 1, 0, 2'b01, 1, 0, 0);
      add("rs_two",   0, 0, 0, 0, 2'b10, 1, 0, 0);
      add("rs_three", 0, 0, 0, 0, 2'b11, 1, 0, 0);
      add("rs_done",  0, 0, 0, 0, 2'b00, 0, 1, 1);
      add("rs_idle2", 0, 0, 0, 0, 2'b00, 0, 0, 1);

      foreach (vecs[i]) apply(vecs[i]);

      // Back-to-back: a new start issued in the done cycle follows after a single 00 cycle.
      tick(1'b1, 4'd1);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick(1'b0, 4'd0);
         if (bus.done === 1'b1) found = 1'b1;
      end
      chk("b2b_done_seen", {31'd0, found}, 32'd1);
      chk("b2b_done_num", {30'd0, bus.num}, 32'd0);

      v.rst = 0; v.ab = 0;
      v.name = "b2b_start"; v.st = 1; v.ones = 2; v.num = 2'b01; v.busy = 1; v.done = 0; v.seen = 0;
      apply(v);
      v.st = 0; v.ones = 0;
      v.name = "b2b_one";   v.num = 2'b01; apply(v);
      v.name = "b2b_two";   v.num = 2'b10; apply(v);
      v.name = "b2b_three"; v.num = 2'b11; apply(v);
      v.name = "b2b_done";  v.num = 2'b00; v.busy = 0; v.done = 1; v.seen = 1; apply(v);
      v.name = "b2b_idle";  v.done = 0; apply(v);

      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
